// File: rtl/fixed_to_float.sv
// Multi-cycle signed Q2.30 to IEEE-754 single-precision converter (one normalising shift per edge).
// Optional build macro: ROUND_NEAREST_EN selects round-to-nearest-even instead of truncation.
module fixed_to_float (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic        start,
  input  logic [31:0] dataa,
  output logic        done,
  output logic [31:0] result
);

  typedef enum logic [1:0] {StIdle, StNorm, StPack} state_e;

  state_e      state_q, state_d;
  logic        sign_q, sign_d;
  logic [31:0] mag_q, mag_d;
  logic [7:0]  exp_q, exp_d;
  logic        done_q, done_d;
  logic [31:0] result_q, result_d;

  logic [22:0] mant_pack;
  logic [7:0]  exp_pack;

`ifdef ROUND_NEAREST_EN
  logic        round_up;
  logic [23:0] mant_sum;

  always_comb begin
    round_up = mag_q[7] & ((|mag_q[6:0]) | mag_q[8]);
    mant_sum = {1'b0, mag_q[30:8]} + {23'd0, round_up};
    // Carry out of the mantissa: significand becomes 2.0, i.e. 1.0 at the next exponent.
    if (mant_sum[23]) begin
      mant_pack = 23'd0;
      exp_pack  = exp_q + 8'd1;
    end else begin
      mant_pack = mant_sum[22:0];
      exp_pack  = exp_q;
    end
  end
`else
  logic unused_round_bits;

  assign unused_round_bits = ^mag_q[7:0];

  always_comb begin
    mant_pack = mag_q[30:8];
    exp_pack  = exp_q;
  end
`endif

  always_comb begin
    state_d  = state_q;
    sign_d   = sign_q;
    mag_d    = mag_q;
    exp_d    = exp_q;
    result_d = result_q;
    done_d   = 1'b0;
    case (state_q)
      StIdle: begin
        if (start) begin
          sign_d  = dataa[31];
          // Two's-complement negate maps 0x80000000 onto itself, which is the wanted magnitude.
          mag_d   = dataa[31] ? (~dataa + 32'd1) : dataa;
          exp_d   = 8'd128;
          state_d = (dataa == 32'd0) ? StPack : StNorm;
        end
      end
      StNorm: begin
        if (mag_q[31]) begin
          state_d = StPack;
        end else begin
          mag_d = {mag_q[30:0], 1'b0};
          exp_d = exp_q - 8'd1;
        end
      end
      StPack: begin
        done_d   = 1'b1;
        state_d  = StIdle;
        result_d = (mag_q == 32'd0) ? 32'd0 : {sign_q, exp_pack, mant_pack};
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= StIdle;
      sign_q   <= 1'b0;
      mag_q    <= 32'd0;
      exp_q    <= 8'd0;
      done_q   <= 1'b0;
      result_q <= 32'd0;
    end else if (clk_en) begin
      state_q  <= state_d;
      sign_q   <= sign_d;
      mag_q    <= mag_d;
      exp_q    <= exp_d;
      done_q   <= done_d;
      result_q <= result_d;
    end
  end

  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_fixed_to_float.sv
// Scoreboard bench for fixed_to_float: driver pushes expected result/latency, monitor checks on done.
// Honours ROUND_NEAREST_EN the same way as the design.
module tb_fixed_to_float;

  logic        clk;
  logic        reset;
  logic        clk_en;
  logic        start;
  logic [31:0] dataa;
  logic        done;
  logic [31:0] result;

  int n_cmp;
  int n_err;
  int ecnt;
  int tot_edges;
  logic en_s;

  logic [31:0] exp_res_q[$];
  int          exp_lat_q[$];
  int          start_idx_q[$];

  fixed_to_float dut (
    .clk    (clk),
    .reset  (reset),
    .clk_en (clk_en),
    .start  (start),
    .dataa  (dataa),
    .done   (done),
    .result (result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact value |d| * 2^-30, normalised with plain integer arithmetic.
  function automatic logic [31:0] ref_model(input logic [31:0] d);
    longint v, m, sig, rem, half;
    int p, e;
    logic [7:0] e8;
    logic [22:0] f23;
    v = longint'($signed(d));
    if (v == 0) return 32'd0;
    m = (v < 0) ? -v : v;
    p = 31;
    while (((m >> p) & 64'd1) == 0) p--;
    e = 127 + p - 30;
    if (p >= 23) begin
      sig = m >> (p - 23);
      rem = m - (sig << (p - 23));
    end else begin
      sig = m << (23 - p);
      rem = 0;
    end
`ifdef ROUND_NEAREST_EN
    if (p > 23) begin
      half = longint'(1) << (p - 24);
      if (rem > half || (rem == half && (sig % 2) == 1)) sig++;
    end
    if (sig == (longint'(1) << 24)) begin
      sig = sig >> 1;
      e++;
    end
`else
    half = rem;
`endif
    e8  = e[7:0];
    f23 = sig[22:0];
    return {d[31], e8, f23};
  endfunction

  function automatic int ref_lat(input logic [31:0] d);
    longint m;
    int p;
    m = longint'($signed(d));
    if (m == 0) return 1;
    if (m < 0) m = -m;
    p = 31;
    while (((m >> p) & 64'd1) == 0) p--;
    return (31 - p) + 2;
  endfunction

  // Monitor: counts enabled edges and checks every done pulse against the scoreboard.
  always @(posedge clk) begin
    en_s = clk_en;
    if (en_s && reset) ecnt++;
    #1;
    if (done && en_s) begin
      if (exp_res_q.size() == 0) begin
        n_cmp++;
        n_err++;
        $display("FAIL unexpected_done: got done=1 result=%08h, required no done", result);
      end else begin
        logic [31:0] er;
        int el, si;
        er = exp_res_q.pop_front();
        el = exp_lat_q.pop_front();
        si = start_idx_q.pop_front();
        n_cmp++;
        if (result !== er) begin
          n_err++;
          $display("FAIL result: got %08h, required %08h", result, er);
        end
        n_cmp++;
        if (ecnt - si != el) begin
          n_err++;
          $display("FAIL latency: got %0d enabled edges, required %0d (result %08h)",
                   ecnt - si, el, er);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
    n_cmp++;
    if (got !== req) begin
      n_err++;
      $display("FAIL %s: got %08h, required %08h", name, got, req);
    end
  endtask

  // Called at a negedge; returns at a negedge with start low and clk_en high.
  task automatic convert(input logic [31:0] d, input logic [31:0] er, input int el,
                         input bit rnd_en, input int dis_from, input int dis_n,
                         input int restart_at, input int exp_tot);
    bit got;
    bit en;
    int edges;
    got   = 1'b0;
    edges = 0;
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = d;
    exp_res_q.push_back(er);
    exp_lat_q.push_back(el);
    start_idx_q.push_back(ecnt + 1);
    @(posedge clk);
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      start = (i == restart_at);
      dataa = (i == restart_at) ? 32'h3000_0000 : $urandom;
      if (i >= dis_from && i < dis_from + dis_n) clk_en = 1'b0;
      else if (rnd_en) clk_en = ($urandom_range(0, 3) != 0);
      else clk_en = 1'b1;
      @(posedge clk);
      en = clk_en;
      edges++;
      #1;
      if (done && en) got = 1'b1;
    end
    @(negedge clk);
    start  = 1'b0;
    clk_en = 1'b1;
    if (!got) begin
      n_cmp++;
      n_err++;
      $display("FAIL timeout: got no done for dataa=%08h, required done", d);
      exp_res_q.delete();
      exp_lat_q.delete();
      start_idx_q.delete();
    end else if (exp_tot > 0) begin
      n_cmp++;
      if (edges != exp_tot) begin
        n_err++;
        $display("FAIL total_latency: got %0d edges, required %0d", edges, exp_tot);
      end
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    ecnt   = 0;
    tot_edges = 0;
    reset  = 1'b0;
    clk_en = 1'b0;
    start  = 1'b0;
    dataa  = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, done}, 32'd0);
    check("reset_result", result, 32'd0);
    reset  = 1'b1;
    @(negedge clk);

    // Directed vectors with hand-derived expectations.
    convert(32'h4000_0000, 32'h3F80_0000, 3, 1'b0, -1, 0, -1, 3);
`ifdef ROUND_NEAREST_EN
    convert(32'h26DD_3B6A, 32'h3F1B_74EE, 4, 1'b0, -1, 0, -1, 4);
`else
    convert(32'h26DD_3B6A, 32'h3F1B_74ED, 4, 1'b0, -1, 0, -1, 4);
`endif
    convert(32'h8000_0000, 32'hC000_0000, 2, 1'b0, -1, 0, -1, 2);
    convert(32'hC000_0000, 32'hBF80_0000, 3, 1'b0, -1, 0, -1, 3);
    convert(32'h0000_0000, 32'h0000_0000, 1, 1'b0, -1, 0, -1, 1);
    // Second start while normalising must be ignored.
    convert(32'h0000_0001, 32'h3080_0000, 33, 1'b0, -1, 0, 5, 33);
    // Five disabled cycles mid-NORM stretch latency from 3 to 8 edges.
    convert(32'h4000_0000, 32'h3F80_0000, 3, 1'b0, 0, 5, -1, 8);
    check("result_hold", result, 32'h3F80_0000);

    // Reset in the middle of a long normalisation.
    clk_en = 1'b1;
    start  = 1'b1;
    dataa  = 32'h0000_0003;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    reset = 1'b0;
    exp_res_q.delete();
    exp_lat_q.delete();
    start_idx_q.delete();
    #1;
    check("midreset_done", {31'd0, done}, 32'd0);
    check("midreset_result", result, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    repeat (40) @(negedge clk);
    check("post_reset_done", {31'd0, done}, 32'd0);
    check("post_reset_result", result, 32'd0);
    convert(32'hC000_0000, 32'hBF80_0000, 3, 1'b0, -1, 0, -1, 3);

    // Randomised operands, half of them with random clock-enable gaps.
    for (int k = 0; k < 60; k++) begin
      logic [31:0] d;
      d = $urandom >> $urandom_range(0, 31);
      if ($urandom_range(0, 1) == 1) d = ~d + 32'd1;
      if (k % 7 == 0) d = $urandom;
      convert(d, ref_model(d), ref_lat(d), (k % 2) == 1, -1, 0, -1, -1);
    end

    repeat (5) @(negedge clk);
    n_cmp++;
    if (exp_res_q.size() != 0) begin
      n_err++;
      $display("FAIL scoreboard_drain: got %0d pending, required 0", exp_res_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/fixed_to_float.md
FIXED_TO_FLOAT -- requirements
Module: fixed_to_float

Interface
REQ-001 The block SHALL have no parameters; the input format is fixed at signed Q2.30, which is the CORDIC cosine stage's result format.
REQ-002 clk  input  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-003 reset  input  1  SHALL be an asynchronous, active-low reset.
REQ-004 clk_en  input  1  SHALL be a clock enable; when it is low, all state, done and result SHALL hold.
REQ-005 start  input  1  SHALL request a conversion of dataa, sampled on an enabled edge.
REQ-006 dataa  input  32  SHALL carry the signed Q2.30 value, range [-2.0, 2.0).
REQ-007 done  output  1  SHALL pulse high for one enabled cycle when result is valid.
REQ-008 result  output  32  SHALL carry the IEEE-754 single-precision equivalent of dataa.

Function
REQ-009 The FSM SHALL have three states, IDLE, NORM and PACK, with IDLE as the reset state.
REQ-010 IDLE + start: capture sign = dataa[31], mag = |dataa| as 32-bit unsigned (0x80000000 -> 0x80000000) and exp = 128.
REQ-011 In the same IDLE + start edge, the next state SHALL be PACK if dataa == 0, and NORM otherwise.
REQ-012 NORM: if mag[31] = 1, go to PACK; otherwise mag <<= 1, exp -= 1 and stay in NORM (one bit per enabled cycle).
REQ-013 PACK: mantissa = mag[30:8]; rounding per REQ-022 (macro defined) or REQ-023 (macro undefined).
REQ-014 PACK: a mantissa carry-out SHALL clear the mantissa and increment exp; exp SHALL never exceed 128, so no overflow handling exists.
REQ-015 PACK: register result = {sign, exp[7:0], mantissa}, assert done for one cycle, and return to IDLE.
REQ-016 Zero input SHALL produce result = 0x00000000 (+0, sign discarded).
REQ-017 Latency SHALL be L+2 enabled edges after the start edge, where L = leading zeros of mag; zero input SHALL take 1 edge; the maximum SHALL be 33.
REQ-018 start outside IDLE, including the PACK cycle, SHALL be ignored; the next start is accepted in the cycle after done.
REQ-019 result SHALL hold its last value until the next PACK; done SHALL be low in every other cycle.
REQ-020 Disabled cycles (clk_en = 0) SHALL stretch latency by exactly the number of disabled cycles, with no lost or repeated shift.

Reset
REQ-021 Asserting reset at any time, including mid-NORM, SHALL immediately force state = IDLE, done = 0, result = 0, mag = 0, exp = 0 and sign = 0; the in-flight conversion is discarded.

Configuration
REQ-022 With ROUND_NEAREST_EN defined, PACK SHALL round to nearest-even: guard = mag[7], sticky = |mag[6:0], lsb = mag[8]; increment the mantissa when guard & (sticky | lsb).
REQ-023 With ROUND_NEAREST_EN undefined, PACK SHALL truncate (mag[7:0] ignored) and the rounding adder SHALL be absent; latency is unchanged.

Verification
REQ-024 dataa = 0x40000000 (1.0) -> result 0x3F800000, done 3 edges after start.
REQ-025 dataa = 0x26DD3B6A -> result 0x3F1B74EE with ROUND_NEAREST_EN, 0x3F1B74ED without; done 4 edges after start.
REQ-026 dataa = 0x80000000 (-2.0) -> 0xC0000000 in 2 edges; dataa = 0xC0000000 (-1.0) -> 0xBF800000 in 3 edges; dataa = 0 -> 0x00000000 in 1 edge.
REQ-027 dataa = 0x00000001 -> result 0x30800000, done 33 edges after start; a second start mid-conversion -> ignored, result unaffected.
REQ-028 dataa = 0x40000000 with clk_en low for 5 cycles mid-NORM -> done 8 edges after start, result 0x3F800000.
REQ-029 reset asserted mid-NORM, then released -> done stays 0, result = 0, state = IDLE; a fresh start then converts correctly.
